// File: rtl/age_issue_sel.sv
// age_issue_sel: oldest-first W-of-N grant selector feeding issue/FU-select.
// Selection is combinational; grants live in a single output register that holds while stalled.
`ifndef XLEN
`define XLEN 32
`endif

module age_issue_sel #(
    parameter int N    = 16,
    parameter int W    = 2,
    parameter int TW   = `XLEN,
    parameter int WRAP = 0
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic [N-1:0]         req,
    input  logic [N-1:0][TW-1:0] age,
    input  logic                 en,
    input  logic                 flush,
    output logic [W-1:0][N-1:0]  gnt,
    output logic [W-1:0]         gnt_valid,
    output logic [W-1:0][TW-1:0] gnt_age
);
    localparam int IW = $clog2(N);

    logic [W-1:0][N-1:0]  gnt_r;
    logic [W-1:0]         gnt_valid_r;
    logic [W-1:0][TW-1:0] gnt_age_r;

    logic [W-1:0][N-1:0]  sel_gnt_s;
    logic [W-1:0]         sel_valid_s;
    logic [W-1:0][TW-1:0] sel_age_s;
    logic [N-1:0]         held_mask_s;
    logic                 load_s;

    // Strictly-older test; the modular form reads the discarded-carry difference as signed
    function automatic logic is_older(input logic [TW-1:0] a, input logic [TW-1:0] b);
        logic result;
        if (WRAP != 0) begin
            result = ($signed(a - b) < $signed({TW{1'b0}}));
        end else begin
            result = (a < b);
        end
        return result;
    endfunction

    // Entries granted in the held register are masked so they are not re-issued while consumed
    always_comb begin
        held_mask_s = {N{1'b0}};
        for (int w = 0; w < W; w++) begin
            held_mask_s = held_mask_s | gnt_r[w];
        end
    end

    assign load_s = en | ~(|gnt_valid_r);

    // Slot-by-slot oldest scan; strict compare keeps the lower index on equal tags
    always_comb begin : select_p
        logic [N-1:0]    rem_s;
        logic            found_s;
        logic            take_s;
        logic [IW-1:0]   best_idx_s;
        logic [TW-1:0]   best_age_s;
        rem_s       = req & ~held_mask_s;
        sel_gnt_s   = {(W*N){1'b0}};
        sel_valid_s = {W{1'b0}};
        sel_age_s   = {(W*TW){1'b0}};
        found_s     = 1'b0;
        take_s      = 1'b0;
        best_idx_s  = {IW{1'b0}};
        best_age_s  = {TW{1'b0}};
        for (int w = 0; w < W; w++) begin
            found_s    = 1'b0;
            best_idx_s = {IW{1'b0}};
            best_age_s = {TW{1'b0}};
            for (int j = 0; j < N; j++) begin
                take_s     = rem_s[j] & (~found_s | is_older(age[j], best_age_s));
                found_s    = found_s | take_s;
                best_idx_s = take_s ? IW'(j) : best_idx_s;
                best_age_s = take_s ? age[j] : best_age_s;
            end
            if (found_s) begin
                sel_gnt_s[w][best_idx_s] = 1'b1;
                sel_valid_s[w]           = 1'b1;
                sel_age_s[w]             = best_age_s;
                rem_s[best_idx_s]        = 1'b0;
            end else begin
                sel_valid_s[w] = 1'b0;
            end
        end
    end

    // Grant register: flush beats load, and without a load every slot holds bit-identical
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            gnt_r       <= {(W*N){1'b0}};
            gnt_valid_r <= {W{1'b0}};
            gnt_age_r   <= {(W*TW){1'b0}};
        end else if (flush) begin
            gnt_r       <= {(W*N){1'b0}};
            gnt_valid_r <= {W{1'b0}};
            gnt_age_r   <= {(W*TW){1'b0}};
        end else if (load_s) begin
            gnt_r       <= sel_gnt_s;
            gnt_valid_r <= sel_valid_s;
            gnt_age_r   <= sel_age_s;
        end else begin
            gnt_r       <= gnt_r;
            gnt_valid_r <= gnt_valid_r;
            gnt_age_r   <= gnt_age_r;
        end
    end

    assign gnt       = gnt_r;
    assign gnt_valid = gnt_valid_r;
    assign gnt_age   = gnt_age_r;

endmodule

// File: doc/age_issue_sel.md
# age_issue_sel

Parametrised oldest-first multi-grant selector with a registered grant stage. Each cycle it picks up to W requesting entries out of N, ordered oldest first by an age tag (PC or ROB sequence number), with optional wrap-around age comparison. Grants are held stable while downstream stalls, and flush clears them. It sits between the reservation station and the issue/FU-select stage, in place of single-grant combinational age trees.

## Interface
- N, default 16: number of requesting entries; power of 2, N >= 2.
- W, default 2: grant slots per cycle; 1 <= W <= N.
- TW, default `XLEN: age tag width.
- WRAP, default 0: age compare mode. 0 = plain unsigned compare; 1 = modular (wrap-around) compare.

Ports:
- clock  in  1  system clock; all state changes on the rising edge.
- reset  in  1  reset; asynchronous, active-low.
- req  in  N  per-entry request.
- age  in  N x TW  per-entry age tag; a smaller tag is older.
- en  in  1  downstream accepts the held grants this cycle.
- flush  in  1  discard the held grants.
- gnt  out  W x N  registered one-hot grant per slot.
- gnt_valid  out  W  slot holds a valid grant.
- gnt_age  out  W x TW  age tag of the granted entry.

## Operation
- **Age order, WRAP=0:** a is older than b iff a < b (unsigned).
- **Age order, WRAP=1:** a is older than b iff (a - b), taken modulo 2^TW and read as a signed TW-bit value, is negative.
- **Ties:** on equal tags, the lower entry index is older.
- **Candidates:** cand = req & ~held_mask.
  - held_mask is the OR of gnt[w] over all valid slots.
  - This prevents re-granting entries whose req is still high in the cycle they are consumed.
- **Slot assignment:**
  - Slot 0 gets the oldest candidate.
  - Slot k gets the oldest candidate not already taken by slots 0..k-1.
  - Slots are filled contiguously from 0.
  - An unused slot has gnt=0, gnt_valid=0, gnt_age=0.
- **Load condition:** load = en | ~(|gnt_valid).
  - Loading replaces all W slots together with the new selection.
  - When load=0, all outputs hold.
- **flush:** takes priority over load. At the next edge, all slots are cleared and nothing new is loaded that cycle.
- **Consumption rule:**
  - A slot's grant is consumed on any edge where en=1 and that slot's gnt_valid=1.
  - The requester must deassert req for a consumed entry by the following cycle. Otherwise it becomes eligible again one cycle later.
- **Width rules:**
  - Index math uses $clog2(N) bits.
  - WRAP compare uses a TW-bit subtraction; the carry is discarded.
- **Invariants:**
  - Grants never duplicate an entry across slots.
  - gnt[w] != 0 iff gnt_valid[w].

## Timing
- **Reset:** reset low clears gnt, gnt_valid and gnt_age to 0 immediately, with no edge required.
  - The block is idle on the first edge after reset deasserts.
  - Reset asserted mid-hold drops the held grants with no consumption.
- **Latency:** req/age sampled in cycle t produce grants visible in cycle t+1. Selection is combinational; the only state is the output register.
- **Stall:**
  - With en=0 and at least one valid slot, outputs remain bit-identical for every stalled cycle, regardless of req/age changes.
  - Entries newly raising req wait for the next load.
- **Empty register:** with all slots invalid, the block loads every cycle whatever the value of en.
- **Back-to-back issue:** en held at 1 with continuous requests yields a fresh set of W grants every cycle.
- **Fewer than W candidates:** the upper slots are invalid.
- **No candidates:** all slots are invalid after the edge.
- **Simultaneous events:**
  - flush with en=1 clears all slots; the selection made that cycle is dropped.
  - flush with req=0 gives the same result as flush alone.

## Test plan
- Reset: drive reset low mid-cycle with valid grants held -> gnt, gnt_valid and gnt_age read 0 before the next edge. After release with req=0, gnt_valid stays 0.
- Basic order (N=16, W=2, WRAP=0): req=0x0105, ages idx0=40, idx2=10, idx8=25 -> after one edge:
  - gnt[0]=0x0004, gnt_age[0]=10
  - gnt[1]=0x0100, gnt_age[1]=25
  - gnt_valid=2'b11
- Tie and partial fill: req=0x0028, idx3 and idx5 both age 7 -> slot0 = idx3 (0x0008), slot1 = idx5 (0x0020).
  - Then req=0x0001 with en=1 -> slot0 = idx0, gnt_valid=2'b01.
- Stall/mask:
  - With grants idx2/idx8 held, drive en=0 for 3 cycles while adding req idx1 age 1 -> outputs unchanged.
  - Then en=1 with req idx2/idx8 still high -> next grants are slot0 = idx1 (age 1), slot1 = idx0 (age 40); idx2/idx8 are not re-granted.
- Wrap mode (WRAP=1, TW=8): idx1 age 0xFE, idx4 age 0x02 -> slot0 = idx1, slot1 = idx4. With WRAP=0, the same stimulus gives slot0 = idx4.
- Flush:
  - flush=1 with en=0 and valid grants -> gnt_valid=0 after the edge.
  - flush=1 and en=1 together -> also empty.
  - Next edge with flush=0 and req pending -> loads normally.
